// File: rtl/ocm_reader_pkg.sv
// Shared types and constants for the on-chip-memory stream reader.
package ocm_reader_pkg;

  localparam int OCM_ADDR_W = 13;
  localparam int OCM_DATA_W = 32;

  // Every read fetches the full 32-bit word.
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ocm_stream_reader_if.sv
// Avalon-MM read channel plus valid/ready output stream of the reader.
// The master modport is the reader's view; the slave modport is the view of
// the memory/consumer side.
interface ocm_stream_reader_if #(
  parameter int ADDR_W = ocm_reader_pkg::OCM_ADDR_W,
  parameter int DATA_W = ocm_reader_pkg::OCM_DATA_W
);
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;

  modport master (
    output avm_address, avm_read, avm_byteenable, st_data, st_valid,
    input  avm_waitrequest, avm_readdata, st_ready
  );

  modport slave (
    input  avm_address, avm_read, avm_byteenable, st_data, st_valid,
    output avm_waitrequest, avm_readdata, st_ready
  );
endinterface

// File: rtl/ocm_reader_fifo.sv
// First-word-fall-through FIFO buffering read returns ahead of the stream.
// DEPTH must be a power of two so the pointers wrap naturally.
module ocm_reader_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != (PTR_W+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_do_push) - (PTR_W+1)'(w_do_pop);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; emptiness is tracked by the pointers,
    // so stale contents are never presented and the array can map to RAM.
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/ocm_stream_reader.sv
// Avalon-MM read master draining a word range of on-chip RAM into a stream.
// Reads are issued against a credit of free FIFO entries, so returns always
// find room. Optional build macro OCM_READER_CHECKSUM_EN adds the `sum`
// output: the modulo-2^DATA_W total of all words popped in the transfer.
module ocm_stream_reader
  import ocm_reader_pkg::*;
#(
  parameter int ADDR_W       = OCM_ADDR_W,
  parameter int DATA_W       = OCM_DATA_W,
  parameter int MEM_DEPTH    = 5000,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              error,
`ifdef OCM_READER_CHECKSUM_EN
  output logic [DATA_W-1:0] sum,
`endif
  ocm_stream_reader_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W:0]         r_count;
  logic [ADDR_W:0]         r_issued;
  logic [ADDR_W:0]         r_returned;
  logic [CNT_W-1:0]        r_outstanding;
  logic [READ_LATENCY-1:0] r_lat_sr;

  logic              w_start_ok;
  logic              w_range_bad;
  logic [ADDR_W+1:0] w_end;
  logic [CNT_W:0]    w_inflight;
  logic              w_credit;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_fifo_data;

  // Range check is done wide enough that base+count can never wrap.
  assign w_end       = (ADDR_W+2)'(base_addr) + (ADDR_W+2)'(num_words);
  assign w_range_bad = w_end > (ADDR_W+2)'(MEM_DEPTH);
  assign w_start_ok  = (r_state == ST_IDLE) && start;

  // Words already requested or buffered must leave room for one more return.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit   = w_inflight < (CNT_W+1)'(FIFO_DEPTH);
  assign w_accept   = bus.avm_read && !bus.avm_waitrequest;
  assign w_push     = r_lat_sr[READ_LATENCY-1];
  assign w_pop      = !w_fifo_empty && bus.st_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decision.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned
    // and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_range_bad)          w_state_nxt = ST_ERR;
          else if (num_words == '0) w_state_nxt = ST_FIN;
          else                      w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (r_issued == r_count) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((r_returned == r_count) && w_fifo_empty) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      ST_ERR:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Status and read-request outputs decoded from the current state.
  always_comb begin
    busy         = (r_state != ST_IDLE);
    done         = (r_state == ST_FIN) || (r_state == ST_ERR);
    error        = (r_state == ST_ERR);
    bus.avm_read = (r_state == ST_ISSUE) && (r_issued < r_count) && w_credit;
  end

  // Transfer counters, address walk and return-latency tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_count       <= '0;
      r_issued      <= '0;
      r_returned    <= '0;
      r_outstanding <= '0;
      r_lat_sr      <= '0;
    end else begin
      if (w_start_ok) begin
        r_count    <= num_words;
        r_issued   <= '0;
        r_returned <= '0;
        if (!w_range_bad) r_addr <= base_addr;
      end
      if (w_accept) begin
        r_issued <= r_issued + (ADDR_W+1)'(1);
        // Stop on the last word so the address never points past the range.
        if ((r_issued + (ADDR_W+1)'(1)) < r_count) r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_push) r_returned <= r_returned + (ADDR_W+1)'(1);
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_push);
      r_lat_sr[0] <= w_accept;
      for (int i = 1; i < READ_LATENCY; i++) r_lat_sr[i] <= r_lat_sr[i-1];
    end
  end

  ocm_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_data  (bus.avm_readdata),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.avm_address    = r_addr;
  assign bus.avm_byteenable = BE_ALL;
  assign bus.st_data        = w_fifo_data;
  assign bus.st_valid       = !w_fifo_empty;

`ifdef OCM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  // Running total of streamed words, restarted by each accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_sum <= '0;
    else if (w_start_ok) r_sum <= '0;
    else if (w_pop)      r_sum <= r_sum + w_fifo_data;
  end

  assign sum = r_sum;
`endif

endmodule
